// File: rtl/pcie_rx_framer.sv
// PCIe RX framing filter: splits the decoded symbol stream into TLP and DLLP
// beat streams, drops idle/ordered sets, and flags malformed packets.
module pcie_rx_framer #(
  parameter int DATA_WIDTH    = 128,
  parameter int MAX_TLP_BYTES = 4116,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_k,
  input  logic                    in_valid,
  output logic [DATA_WIDTH-1:0]   tlp_data,
  output logic [DATA_WIDTH/8-1:0] tlp_keep,
  output logic                    tlp_valid,
  output logic                    tlp_sop,
  output logic                    tlp_eop,
  output logic                    tlp_err,
  output logic [DATA_WIDTH-1:0]   dllp_data,
  output logic [DATA_WIDTH/8-1:0] dllp_keep,
  output logic                    dllp_valid,
  output logic                    dllp_sop,
  output logic                    dllp_eop,
  output logic                    dllp_err,
  output logic [CNT_W-1:0]        tlp_cnt,
  output logic [CNT_W-1:0]        dllp_cnt,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int SYMS   = DATA_WIDTH / 8;
  localparam int BCNT_W = $clog2(MAX_TLP_BYTES + SYMS + 1);

  localparam logic [BCNT_W-1:0] MAX_B    = BCNT_W'(MAX_TLP_BYTES);
  localparam logic [BCNT_W-1:0] TLP_MIN  = BCNT_W'(18);
  localparam logic [BCNT_W-1:0] DLLP_LEN = BCNT_W'(6);

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TLP,
    S_DLLP,
    S_DROP
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [SYMS-1:0]       keep;
    logic                  valid;
    logic                  sop;
    logic                  eop;
    logic                  err;
  } beat_t;

  state_t            state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  beat_t             tlp_q, tlp_d;
  beat_t             dllp_q, dllp_d;
  logic [CNT_W-1:0]  tlp_cnt_q, tlp_cnt_d;
  logic [CNT_W-1:0]  dllp_cnt_q, dllp_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Per-beat scan temporaries
  logic              active, is_tlp, sop_v, done;
  logic              term, edb, abort, ovf, ovf_term, bad;
  logic [SYMS-1:0]   keep_v;
  logic [BCNT_W-1:0] cnt_v;
  logic [7:0]        sym;
  beat_t             beat_v;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    tlp_d      = '0;
    dllp_d     = '0;
    tlp_cnt_d  = tlp_cnt_q;
    dllp_cnt_d = dllp_cnt_q;
    err_cnt_d  = err_cnt_q;
    active     = 1'b0;
    is_tlp     = 1'b0;
    sop_v      = 1'b0;
    done       = 1'b0;
    term       = 1'b0;
    edb        = 1'b0;
    abort      = 1'b0;
    ovf        = 1'b0;
    ovf_term   = 1'b0;
    bad        = 1'b0;
    keep_v     = '0;
    cnt_v      = bcnt_q;
    sym        = '0;
    beat_v     = '0;

    if (in_valid) begin
      case (state_q)
        S_IDLE: begin
          if (in_k[0] && in_data[7:0] == K_STP) begin
            active = 1'b1;
            is_tlp = 1'b1;
            sop_v  = 1'b1;
            cnt_v  = '0;
          end else if (in_k[0] && in_data[7:0] == K_SDP) begin
            active = 1'b1;
            sop_v  = 1'b1;
            cnt_v  = '0;
          end
        end
        S_TLP: begin
          active = 1'b1;
          is_tlp = 1'b1;
        end
        S_DLLP: active = 1'b1;
        S_DROP: begin
          for (int i = 0; i < SYMS; i++) begin
            sym = in_data[8*i +: 8];
            if (in_k[i] && (sym == K_END || sym == K_EDB)) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (active) begin
        // NOTE: blocking assignments here model the in-order symbol walk; the
        // registers themselves are only ever written with <= below.
        for (int i = 0; i < SYMS; i++) begin
          sym = in_data[8*i +: 8];
          if (!(sop_v && i == 0)) begin
            if (!done) begin
              if (in_k[i]) begin
                done = 1'b1;
                if (sym == K_END || sym == K_EDB) begin
                  term = 1'b1;
                  edb  = (sym == K_EDB);
                end else begin
                  abort = 1'b1;
                end
              end else if (is_tlp && cnt_v >= MAX_B) begin
                ovf  = 1'b1;
                done = 1'b1;
              end else begin
                keep_v[i] = 1'b1;
                // Saturate so an endless DLLP can never wrap back to a legal length
                if (!(&cnt_v)) cnt_v = cnt_v + BCNT_W'(1);
              end
            end else if (ovf && in_k[i] && (sym == K_END || sym == K_EDB)) begin
              ovf_term = 1'b1;
            end
          end
        end

        if (term) bad = edb || (is_tlp ? (cnt_v < TLP_MIN) : (cnt_v != DLLP_LEN));

        beat_v.data  = in_data;
        beat_v.keep  = ovf ? '0 : keep_v;
        beat_v.valid = 1'b1;
        beat_v.sop   = sop_v;
        beat_v.eop   = term | abort | ovf;
        beat_v.err   = bad | abort | ovf;

        if (is_tlp) tlp_d  = beat_v;
        else        dllp_d = beat_v;

        if (beat_v.eop) begin
          bcnt_d = '0;
          if (beat_v.err)  err_cnt_d  = sat_inc(err_cnt_q);
          else if (is_tlp) tlp_cnt_d  = sat_inc(tlp_cnt_q);
          else             dllp_cnt_d = sat_inc(dllp_cnt_q);
          // An overlength TLP whose terminator is already in this beat needs no drop phase
          state_d = (ovf && !ovf_term) ? S_DROP : S_IDLE;
        end else begin
          bcnt_d  = cnt_v;
          state_d = is_tlp ? S_TLP : S_DLLP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bcnt_q     <= '0;
      tlp_q      <= '0;
      dllp_q     <= '0;
      tlp_cnt_q  <= '0;
      dllp_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      tlp_q      <= tlp_d;
      dllp_q     <= dllp_d;
      tlp_cnt_q  <= tlp_cnt_d;
      dllp_cnt_q <= dllp_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign tlp_data   = tlp_q.data;
  assign tlp_keep   = tlp_q.keep;
  assign tlp_valid  = tlp_q.valid;
  assign tlp_sop    = tlp_q.sop;
  assign tlp_eop    = tlp_q.eop;
  assign tlp_err    = tlp_q.err;
  assign dllp_data  = dllp_q.data;
  assign dllp_keep  = dllp_q.keep;
  assign dllp_valid = dllp_q.valid;
  assign dllp_sop   = dllp_q.sop;
  assign dllp_eop   = dllp_q.eop;
  assign dllp_err   = dllp_q.err;
  assign tlp_cnt    = tlp_cnt_q;
  assign dllp_cnt   = dllp_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pcie_rx_framer.sv
// Self-checking bench for pcie_rx_framer: table of beats with hand-derived
// expected outputs, checked through a one-deep scoreboard queue.
`timescale 1ns/1ps
module tb_pcie_rx_framer;

  localparam int DW   = 128;
  localparam int SYMS = 16;
  localparam int MAXB = 64;
  localparam int CW   = 16;
  localparam int SCW  = 3;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;

  typedef struct packed {
    logic            r;
    logic            v;
    logic [DW-1:0]   d;
    logic [SYMS-1:0] k;
  } in_t;

  typedef struct packed {
    logic            tv;
    logic            dv;
    logic [SYMS-1:0] keep;
    logic            sop;
    logic            eop;
    logic            err;
  } exp_t;

  typedef struct {
    string name;
    in_t   stim;
    exp_t  ex;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   in_data;
  logic [SYMS-1:0] in_k;
  logic            in_valid;

  logic [DW-1:0]   tlp_data, dllp_data;
  logic [SYMS-1:0] tlp_keep, dllp_keep;
  logic            tlp_valid, tlp_sop, tlp_eop, tlp_err;
  logic            dllp_valid, dllp_sop, dllp_eop, dllp_err;
  logic [CW-1:0]   tlp_cnt, dllp_cnt, err_cnt;

  logic [DW-1:0]   s_tlp_data, s_dllp_data;
  logic [SYMS-1:0] s_tlp_keep, s_dllp_keep;
  logic            s_tlp_valid, s_tlp_sop, s_tlp_eop, s_tlp_err;
  logic            s_dllp_valid, s_dllp_sop, s_dllp_eop, s_dllp_err;
  logic [SCW-1:0]  s_tlp_cnt, s_dllp_cnt, s_err_cnt;

  int checks   = 0;
  int failures = 0;
  int e_t = 0, e_d = 0, e_e = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  pcie_rx_framer #(.DATA_WIDTH(DW), .MAX_TLP_BYTES(MAXB), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_k(in_k), .in_valid(in_valid),
    .tlp_data(tlp_data), .tlp_keep(tlp_keep), .tlp_valid(tlp_valid),
    .tlp_sop(tlp_sop), .tlp_eop(tlp_eop), .tlp_err(tlp_err),
    .dllp_data(dllp_data), .dllp_keep(dllp_keep), .dllp_valid(dllp_valid),
    .dllp_sop(dllp_sop), .dllp_eop(dllp_eop), .dllp_err(dllp_err),
    .tlp_cnt(tlp_cnt), .dllp_cnt(dllp_cnt), .err_cnt(err_cnt)
  );

  // Narrow-counter instance: its statistics hit all-ones within this run
  pcie_rx_framer #(.DATA_WIDTH(DW), .MAX_TLP_BYTES(MAXB), .CNT_W(SCW)) u_sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_k(in_k), .in_valid(in_valid),
    .tlp_data(s_tlp_data), .tlp_keep(s_tlp_keep), .tlp_valid(s_tlp_valid),
    .tlp_sop(s_tlp_sop), .tlp_eop(s_tlp_eop), .tlp_err(s_tlp_err),
    .dllp_data(s_dllp_data), .dllp_keep(s_dllp_keep), .dllp_valid(s_dllp_valid),
    .dllp_sop(s_dllp_sop), .dllp_eop(s_dllp_eop), .dllp_err(s_dllp_err),
    .tlp_cnt(s_tlp_cnt), .dllp_cnt(s_dllp_cnt), .err_cnt(s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic in_t dbeat();
    in_t b;
    b.r = 1'b0;
    b.v = 1'b1;
    b.k = '0;
    b.d = {$urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  function automatic in_t nob();
    in_t b = dbeat();
    b.v = 1'b0;
    return b;
  endfunction

  function automatic in_t setk(input in_t b, input int idx, input logic [7:0] code);
    in_t o = b;
    o.d[8*idx +: 8] = code;
    o.k[idx]        = 1'b1;
    return o;
  endfunction

  function automatic in_t lead(input logic [7:0] code);
    return setk(dbeat(), 0, code);
  endfunction

  function automatic in_t term_at(input int idx, input logic [7:0] code);
    return setk(dbeat(), idx, code);
  endfunction

  function automatic exp_t ex(input logic tv, input logic dv, input logic [SYMS-1:0] keep,
                              input logic sop, input logic eop, input logic err);
    exp_t e;
    e.tv = tv; e.dv = dv; e.keep = keep; e.sop = sop; e.eop = eop; e.err = err;
    return e;
  endfunction

  function automatic logic [SCW-1:0] sat(input int n);
    return (n > 7) ? 3'd7 : SCW'(n);
  endfunction

  task automatic add(input string n, input in_t b, input exp_t e);
    vec_t v;
    v.name = n;
    v.stim = b;
    v.ex   = e;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v);
    vec_t        e;
    logic [39:0] got_fl, exp_fl;
    @(negedge clk);
    rst      = v.stim.r;
    in_valid = v.stim.v;
    in_data  = v.stim.d;
    in_k     = v.stim.k;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got_fl = {tlp_valid, tlp_sop, tlp_eop, tlp_err, tlp_keep,
              dllp_valid, dllp_sop, dllp_eop, dllp_err, dllp_keep};
    exp_fl = {e.ex.tv ? {1'b1, e.ex.sop, e.ex.eop, e.ex.err, e.ex.keep} : 20'd0,
              e.ex.dv ? {1'b1, e.ex.sop, e.ex.eop, e.ex.err, e.ex.keep} : 20'd0};
    check({e.name, ".flags"}, 128'(got_fl), 128'(exp_fl));
    check({e.name, ".tdata"}, tlp_data, e.ex.tv ? e.stim.d : '0);
    check({e.name, ".ddata"}, dllp_data, e.ex.dv ? e.stim.d : '0);
    if (e.stim.r) begin
      e_t = 0; e_d = 0; e_e = 0;
    end else if (e.ex.eop) begin
      if (e.ex.err)     e_e++;
      else if (e.ex.tv) e_t++;
      else              e_d++;
    end
    check({e.name, ".cnt"}, 128'({tlp_cnt, dllp_cnt, err_cnt}),
          128'({CW'(e_t), CW'(e_d), CW'(e_e)}));
    check({e.name, ".satcnt"}, 128'({s_tlp_cnt, s_dllp_cnt, s_err_cnt}),
          128'({sat(e_t), sat(e_d), sat(e_e)}));
  endtask

  in_t  b;
  exp_t none;
  vec_t hv;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_k     = '0;
    none     = ex(0, 0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.flags", 128'({tlp_valid, tlp_sop, tlp_eop, tlp_err, tlp_keep,
                               dllp_valid, dllp_sop, dllp_eop, dllp_err, dllp_keep}), '0);
    check("reset.data", tlp_data | dllp_data, '0);
    check("reset.cnt", 128'({tlp_cnt, dllp_cnt, err_cnt}), '0);

    // Stimulus table: one input beat and the output it must produce one cycle later
    add("idle0", nob(), none);
    b = setk(lead(K_SDP), 7, K_END);
    for (int i = 8; i < SYMS; i++) b = setk(b, i, K_PAD);
    add("dllp_good", b, ex(0, 1, 16'h007E, 1, 1, 0));
    add("tlp34_sop", lead(K_STP), ex(1, 0, 16'hFFFE, 1, 0, 0));
    add("tlp34_mid", dbeat(), ex(1, 0, 16'hFFFF, 0, 0, 0));
    add("tlp34_eop", term_at(3, K_END), ex(1, 0, 16'h0007, 0, 1, 0));
    add("gap0", nob(), none);
    add("null_sop", lead(K_STP), ex(1, 0, 16'hFFFE, 1, 0, 0));
    add("null_gap", nob(), none);
    add("null_mid", dbeat(), ex(1, 0, 16'hFFFF, 0, 0, 0));
    add("null_eop", term_at(3, K_EDB), ex(1, 0, 16'h0007, 0, 1, 1));
    add("tlp_short10", setk(lead(K_STP), 11, K_END), ex(1, 0, 16'h07FE, 1, 1, 1));
    add("dllp_short5", setk(lead(K_SDP), 6, K_END), ex(0, 1, 16'h003E, 1, 1, 1));
    add("dllp_edb", setk(lead(K_SDP), 7, K_EDB), ex(0, 1, 16'h007E, 1, 1, 1));
    add("abort_sop", lead(K_STP), ex(1, 0, 16'hFFFE, 1, 0, 0));
    add("abort_com", term_at(4, K_COM), ex(1, 0, 16'h000F, 0, 1, 1));
    add("b2b_sop", lead(K_STP), ex(1, 0, 16'hFFFE, 1, 0, 0));
    add("end_at_p0", term_at(0, K_END), ex(1, 0, 16'h0000, 0, 1, 1));
    add("len18_sop", lead(K_STP), ex(1, 0, 16'hFFFE, 1, 0, 0));
    add("len18_eop", term_at(3, K_END), ex(1, 0, 16'h0007, 0, 1, 0));
    add("len17_sop", lead(K_STP), ex(1, 0, 16'hFFFE, 1, 0, 0));
    add("len17_eop", term_at(2, K_END), ex(1, 0, 16'h0003, 0, 1, 1));
    add("idle_com", lead(K_COM), none);
    add("idle_idl", lead(K_IDL), none);
    add("idle_skp", lead(K_SKP), none);
    b = dbeat();
    b.d[7:0] = K_STP;
    add("idle_data_fb", b, none);
    add("idle_end", lead(K_END), none);
    add("idle_stp_at5", term_at(5, K_STP), none);
    add("len64_sop", lead(K_STP), ex(1, 0, 16'hFFFE, 1, 0, 0));
    for (int i = 0; i < 3; i++) add($sformatf("len64_mid%0d", i), dbeat(), ex(1, 0, 16'hFFFF, 0, 0, 0));
    add("len64_eop", term_at(1, K_END), ex(1, 0, 16'h0001, 0, 1, 0));
    add("ovf_sop", lead(K_STP), ex(1, 0, 16'hFFFE, 1, 0, 0));
    for (int i = 0; i < 3; i++) add($sformatf("ovf_mid%0d", i), dbeat(), ex(1, 0, 16'hFFFF, 0, 0, 0));
    add("ovf_cross", dbeat(), ex(1, 0, 16'h0000, 0, 1, 1));
    add("ovf_drop", dbeat(), none);
    add("ovf_drop_end", term_at(5, K_END), none);
    add("after_drop_dllp", setk(lead(K_SDP), 7, K_END), ex(0, 1, 16'h007E, 1, 1, 0));

    foreach (vecs[i]) step(vecs[i]);

    // Push DLLP count past the narrow instance's all-ones value
    for (int i = 0; i < 7; i++) begin
      hv.name = $sformatf("sat_dllp%0d", i);
      hv.stim = setk(lead(K_SDP), 7, K_END);
      hv.ex   = ex(0, 1, 16'h007E, 1, 1, 0);
      step(hv);
    end

    // Reset in the middle of a TLP: no eop, everything cleared
    hv.name = "rst_tlp_sop";
    hv.stim = lead(K_STP);
    hv.ex   = ex(1, 0, 16'hFFFE, 1, 0, 0);
    step(hv);
    hv.name = "rst_mid";
    hv.stim = dbeat();
    hv.stim.r = 1'b1;
    hv.ex   = none;
    step(hv);
    hv.name = "rst_stale_end";
    hv.stim = term_at(3, K_END);
    hv.ex   = none;
    step(hv);
    hv.name = "rst_new_dllp";
    hv.stim = setk(lead(K_SDP), 7, K_END);
    hv.ex   = ex(0, 1, 16'h007E, 1, 1, 0);
    step(hv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
